// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Generic pipeline stage register with a two-entry skid buffer. It sits between
// two pipeline stages and registers the upstream ready path, so in_ready never
// depends combinationally on out_ready. Instruction order is strictly FIFO.
// The stage also counts downstream stall cycles for performance monitoring.
//
// The state is carried by the two entry valid bits {m_valid, s_valid}:
//   EMPTY = 00, ONE = 10, TWO = 11   (01 is unreachable)
//
// Command priority: rst > flush > freeze > normal handshaking.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous squash of all held entries (overrides freeze)
//   freeze     in   synchronous hold: no state change, no handshakes
//   in_valid   in   upstream offers {in_pc, in_data}
//   in_ready   out  stage can accept this cycle
//   in_pc      in   upstream PC            [PC_W]
//   in_data    in   upstream payload       [DATA_W]
//   out_valid  out  main entry presented downstream
//   out_ready  in   downstream accepts
//   out_pc     out  main entry PC          [PC_W]
//   out_data   out  main entry payload     [DATA_W]
//   stall_cnt  out  saturating count of downstream stall cycles [CNT_W]
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        PC_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {m_valid, s_valid}, so the valid bits fall straight out of it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     m_pc_q,   m_pc_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [PC_W-1:0]     s_pc_q,   s_pc_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic m_valid;
  logic s_valid;
  logic in_fire;
  logic out_fire;

  assign m_valid = state_q[1];
  assign s_valid = state_q[0];

  // in_ready depends on registered state and freeze only: this is what cuts
  // the combinational ready chain between stages.
  assign in_ready  = ~s_valid & ~freeze;
  assign out_valid = m_valid & ~freeze;
  assign out_pc    = m_pc_q;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath steering
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    m_pc_d   = m_pc_q;
    m_data_d = m_data_q;
    s_pc_d   = s_pc_q;
    s_data_d = s_data_q;

    if (flush) begin
      // An input offered in this cycle is dropped even if in_ready was high.
      state_d  = ST_EMPTY;
      m_pc_d   = '0;
      m_data_d = NOP_VAL;
    end else if (!freeze) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_ONE;
            m_pc_d   = in_pc;
            m_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_pc_d   = in_pc;
            m_data_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the newer entry behind the main one.
            state_d  = ST_TWO;
            s_pc_d   = in_pc;
            s_data_d = in_data;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move. Main
          // reloads from skid on the same edge, leaving no output bubble.
          if (out_fire) begin
            state_d  = ST_ONE;
            m_pc_d   = s_pc_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stall cycles: an entry is presented but refused. out_valid already folds
  // in freeze, so the counter holds while frozen. Flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      m_pc_q      <= '0;
      m_data_q    <= NOP_VAL;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_pc_q      <= m_pc_d;
      m_data_q    <= m_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: the skid payload is only ever read while s_valid is set, and s_valid
  // is reset, so the payload itself carries no reset.
  always_ff @(posedge clk) begin
    s_pc_q   <= s_pc_d;
    s_data_q <= s_data_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Self-checking bench for pipe_stage_skid_reg. The reference model is a queue
// of at most two pending entries plus the last value shown on out_pc/out_data.
// Inputs change just after the falling edge; outputs are compared one time
// unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

  localparam int unsigned       DATA_W = 32;
  localparam int unsigned       PC_W   = 32;
  localparam int unsigned       CNT_W  = 4;
  localparam logic [DATA_W-1:0] NOP    = 32'h0000_0013;
  localparam int unsigned       VEC_W  = 2 + PC_W + DATA_W + CNT_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              freeze = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model state
  entry_t           mq[$];
  entry_t           m_main;
  logic [CNT_W-1:0] m_cnt;

  pipe_stage_skid_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .NOP_VAL(NOP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .freeze   (freeze),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic exp_in_ready();
    return (mq.size() < 2) && !freeze;
  endfunction

  function automatic logic exp_out_valid();
    return (mq.size() > 0) && !freeze;
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    return {exp_in_ready(), exp_out_valid(), m_main.pc, m_main.data, m_cnt};
  endfunction

  function automatic logic [VEC_W-1:0] obs_vec();
    return {in_ready, out_valid, out_pc, out_data, stall_cnt};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_main = '{pc: '0, data: NOP};
    m_cnt  = '0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic   do_in;
    logic   do_out;
    entry_t e;
    do_in  = in_valid && exp_in_ready();
    do_out = exp_out_valid() && out_ready;
    if (exp_out_valid() && !out_ready && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (flush) begin
      mq.delete();
      m_main = '{pc: '0, data: NOP};
    end else if (!freeze) begin
      if (do_out) e = mq.pop_front();
      if (do_in) mq.push_back('{pc: in_pc, data: in_data});
      if (mq.size() > 0) m_main = mq[0];
    end
  endtask

  // Advance one clock: model follows the rising edge, return at the falling one.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc,
                       input logic [DATA_W-1:0] d, input logic ordy,
                       input logic fl, input logic fz);
    in_valid  = v;
    in_pc     = pc;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    freeze    = fz;
  endtask

  task automatic reset_dut();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [VEC_W-1:0] want;
    reset_dut();
    want = {1'b1, 1'b0, {PC_W{1'b0}}, NOP, {CNT_W{1'b0}}};
    #1;
    total++;
    if (obs_vec() !== want)
      $display("FAIL reset_values got %h expected %h", obs_vec(), want);
    else passed++;
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] dat [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, PC_W'(4 * i), dat[i], 1'b1, 1'b0, 1'b0);
      else       drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL streaming[%0d] got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_skid_fill();
    logic [DATA_W-1:0] dat [3] = '{32'hDDDD_0004, 32'hEEEE_0005, 32'hFFFF_0006};
    int k = 0;
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      if (k < 3) drive(1'b1, PC_W'(32'h10 + 4 * k), dat[k], c >= 3, 1'b0, 1'b0);
      else       drive(1'b0, '0, '0, c >= 3, 1'b0, 1'b0);
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL skid_fill[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      if (k < 3 && exp_in_ready()) k++;
      tick();
    end
    // Exactly two stalled cycles: ONE and TWO with out_ready low.
    total++;
    if (stall_cnt !== CNT_W'(2))
      $display("FAIL skid_fill_stalls got %0d expected 2", stall_cnt);
    else passed++;
  endtask

  task automatic test_flush_two();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 32'h10, 32'hDDDD_0004, 1'b0, 1'b0, 1'b0);
        1: drive(1'b1, 32'h14, 32'hEEEE_0005, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, 32'h18, 32'hFFFF_0006, 1'b0, 1'b1, 1'b0);
        default: drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      endcase
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL flush_two[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_freeze();
    reset_dut();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:          drive(1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        1, 2, 3:    drive(1'b1, 32'h44, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b1);
        default:    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      endcase
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL freeze[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_flush_freeze();
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       drive(1'b1, 32'h80, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        1:       drive(1'b1, 32'h84, 32'h6666_BBBB, 1'b0, 1'b1, 1'b1);
        default: drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      endcase
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL flush_freeze[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    total++;
    if (out_data !== NOP || out_valid !== 1'b0)
      $display("FAIL flush_freeze_nop got data=%h valid=%b expected data=%h valid=0",
               out_data, out_valid, NOP);
    else passed++;
  endtask

  task automatic test_saturation();
    reset_dut();
    drive(1'b1, 32'hC0, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL saturation[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    total++;
    if (stall_cnt !== 4'd15)
      $display("FAIL saturation_final got %0d expected 15", stall_cnt);
    else passed++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0);
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [VEC_W-1:0] want;
    // Build up two entries and some stall count, then reset between edges.
    drive(1'b1, 32'hE0, 32'h9999_0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hE4, 32'h9999_0002, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hE8, 32'h9999_0003, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    want = {1'b1, 1'b0, {PC_W{1'b0}}, NOP, {CNT_W{1'b0}}};
    total++;
    if (obs_vec() !== want)
      $display("FAIL async_reset got %h expected %h", obs_vec(), want);
    else passed++;
    #1 rst = 1'b0;
    model_reset();
    // Released mid-stream: restarts empty and the old entries never return.
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 32'hF0, 32'h4242_4242, 1'b1, 1'b0, 1'b0);
      tick();
      #1;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL async_restart[%0d] got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush_two();
    test_freeze();
    test_flush_freeze();
    test_saturation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case a task ever stalls on the clock.
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
